axil_uart_io_ring: RTL and testbench
====================================

Name: axil_uart_io_ring

Overview:
Second-generation UART I/O controller. One AXI4-lite master drives an AXI UART-Lite peripheral.
- RX bytes are packed into words and written to BRAM port A as a wrap-around ring buffer. The core reads that ring through consumer_pointer.
- Core output bytes are buffered in a TX FIFO. Core stores no longer wait for each UART write to complete.
- Sits between the core's I/O instructions and the UART block.

Parameters:
BYTES_PER_WORD, 4, RX bytes packed per BRAM word (1, 2 or 4), little-endian (first byte in bits [7:0]).
RING_BASE, 0, first BRAM word address of RX ring.
RING_DEPTH, 1024, ring size in words (>=2).
TX_DEPTH, 16, TX FIFO entries, power of 2.
UART_BASE, 32'h0, AXI base address of UART. RX FIFO at +0, TX FIFO at +4, STAT at +8.
IGNORE_IN_BUSY, 1'b0, 1 forces in_busy=0 (debug).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
out_req  in  1  push out_data[7:0] to TX FIFO; accepted when out_busy=0
out_data  in  WORD_W  only bits [7:0] used
out_busy  out  1  TX FIFO full
consumer_pointer  in  ADDR_W  next ring word the core will read
in_busy  out  1  ring empty (consumer_pointer==prod_pointer)
prod_pointer  out  ADDR_W  next ring word to be written
mem_addr  out  ADDR_W  BRAM address
mem_data  out  WORD_W  BRAM write data
mem_we  out  1  BRAM write enable, one-cycle pulse
axi_aw*/w*/b*/ar*/r*  —  standard AXI4-lite master channels, 32-bit; prot=0; wstrb=4'b0001
err_count  out  16  present only with UART_IO_ERR_CNT_EN

Behaviour:
Reset
- Asynchronous, active-low. Reset mid-transaction abandons it; no attempt to complete.
- Reset values: all valid/ready outputs and mem_we are 0; addr/data outputs are 0.
- prod_pointer=RING_BASE; TX FIFO empty; byte index 0; sequencer in STAT_AR; tx_enabled=0.

Sequencer (single AXI master, one transaction in flight)
- States: STAT_AR, STAT_R, DECIDE, RX_AR, RX_R, TX_AW_W, TX_B.
- STAT_AR → STAT_R: arvalid=1, araddr=UART_BASE+8. Hold until arready, then arvalid=0, rready=1.
- STAT_R: on rvalid, latch STAT, rready=0 → DECIDE.
- tx_enabled is set on the first STAT read with bit2 (TX empty)=1.

DECIDE (combinational choice, registered transition)
- rx_ok = STAT[0] && !(byte_idx==BYTES_PER_WORD-1 && ring_full).
- tx_ok = tx_enabled && fifo_nonempty && !STAT[3].
- Both ok: round-robin; the side not served last wins.
- Only one ok: that side goes (RX_AR or TX_AW_W).
- Neither ok: back to STAT_AR.

RX path
- RX_AR / RX_R mirror the STAT states with araddr=UART_BASE+0.
- On the R handshake, rdata[7:0] goes into byte lane byte_idx and byte_idx increments.
- On the last lane: next cycle mem_we=1, mem_addr=prod_pointer, mem_data=packed word, byte_idx=0.
- One cycle after mem_we, prod_pointer advances. The BRAM write therefore precedes pointer visibility.
- Then → STAT_AR.

TX path
- TX_AW_W: awvalid=wvalid=1, awaddr=UART_BASE+4, wdata={24'b0,fifo_head}.
- Each of awvalid/wvalid drops independently on its ready. When both handshakes are done: bready=1 → TX_B.
- TX_B: on bvalid, bready=0, pop FIFO → STAT_AR.

Ring
- Wrap: RING_BASE+RING_DEPTH-1 → RING_BASE.
- ring_full = next(prod_pointer)==consumer_pointer. One slot is always unused.
- Full ring stalls only the completing byte read. UART backpressure holds the data; nothing is dropped.

TX FIFO
- Push and pop in the same cycle are both performed; count unchanged.
- out_req while full is ignored.
- out_busy is registered and reflects the count after the update.

Optional Feature:
UART_IO_ERR_CNT_EN
- Defined: err_count port exists. It increments (saturating at 16'hFFFF) on each R or B handshake whose resp != OKAY.
- A TX write with error is still popped (no retry).
- Undefined: port and logic absent; resp inputs ignored.

Decomposition:
Package uart_io_pkg holds:
- register offsets RX_FIFO_OFS, TX_FIFO_OFS, STAT_OFS;
- STAT bit indices RX_VALID=0, TX_EMPTY=2, TX_FULL=3;
- AXI_RESP_OKAY;
- typedef enum seq_state_t.

Sub-module io_tx_fifo: byte FIFO, parameter DEPTH, ports push/din/pop/dout/full/empty, async active-low reset.

Test Plan:
1. Reset mid-TX_AW_W (awvalid=1) → all AXI valids 0 the same cycle; prod_pointer=RING_BASE; out_busy=0.
2. STAT=0x05, four RX reads return 0x11,0x22,0x33,0x44 (BYTES_PER_WORD=4) → one mem_we with mem_data=0x44332211 at addr RING_BASE. Next cycle prod_pointer=RING_BASE+1 and in_busy drops.
3. RING_DEPTH=4, consumer_pointer=RING_BASE, 3 words received → prod_pointer=RING_BASE+3. The 4th word's last byte is not read until consumer_pointer=RING_BASE+1, then it is written at RING_BASE+3 and prod_pointer wraps to RING_BASE.
4. Push 16 bytes 0x00..0x0F in consecutive cycles with TX_DEPTH=16 and awready low → out_busy=1 after the 16th push. The 17th push is ignored. Bytes then appear on wdata in order 0x00..0x0F.
5. STAT=0x05 with TX FIFO nonempty for successive polls → RX and TX transactions alternate. STAT[3]=1 → no TX write issued.
6. With UART_IO_ERR_CNT_EN: bresp=2'b10 on two writes → err_count=2 and both bytes popped.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared constants and sequencer state type for the AXI-lite UART I/O ring controller.
package uart_io_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [31:0] RX_FIFO_OFS = 32'h0;
    localparam logic [31:0] TX_FIFO_OFS = 32'h4;
    localparam logic [31:0] STAT_OFS    = 32'h8;

    localparam int unsigned RX_VALID = 0;
    localparam int unsigned TX_EMPTY = 2;
    localparam int unsigned TX_FULL  = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        STAT_AR,
        STAT_R,
        DECIDE,
        RX_AR,
        RX_R,
        TX_AW_W,
        TX_B
    } seq_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO buffering core output bytes ahead of the UART write sequencer.
// Registered full/empty flags reflect the occupancy after the current update.
module io_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_c;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        count_c   = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push_c);
            rd_ptr <= rd_ptr + PTR_W'(do_pop_c);
            count  <= count_c;
            full   <= (count_c == CNT_W'(DEPTH));
            empty  <= (count_c == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/axil_uart_io_ring.sv
// AXI4-lite master polling a UART-Lite: RX bytes packed into a BRAM ring, TX bytes drained from a FIFO.
// Optional UART_IO_ERR_CNT_EN adds err_count, counting non-OKAY R/B responses.
module axil_uart_io_ring
    import uart_io_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned RING_BASE      = 0,
    parameter int unsigned RING_DEPTH     = 1024,
    parameter int unsigned TX_DEPTH       = 16,
    parameter logic [31:0] UART_BASE      = 32'h0,
    parameter bit          IGNORE_IN_BUSY = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              out_req,
    input  logic [WORD_W-1:0] out_data,
    output logic              out_busy,
    input  logic [ADDR_W-1:0] consumer_pointer,
    output logic              in_busy,
    output logic [ADDR_W-1:0] prod_pointer,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_we,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [31:0]       axi_awaddr,
    output logic [2:0]        axi_awprot,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic [31:0]       axi_wdata,
    output logic [3:0]        axi_wstrb,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    input  logic [1:0]        axi_bresp,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [31:0]       axi_araddr,
    output logic [2:0]        axi_arprot,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [31:0]       axi_rdata,
    input  logic [1:0]        axi_rresp
`ifdef UART_IO_ERR_CNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    seq_state_t        state;
    logic [3:0]        stat;
    logic              tx_enabled;
    logic              last_tx;
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] pack;

    logic              tx_push_c;
    logic              tx_pop_c;
    logic [7:0]        tx_dout;
    logic              tx_full;
    logic              tx_empty;

    logic [ADDR_W-1:0] prod_next_c;
    logic              ring_full_c;
    logic              last_lane_c;
    logic              rx_ok_c;
    logic              tx_ok_c;
    logic [WORD_W-1:0] word_c;

    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;
    assign axi_wstrb  = 4'b0001;
    assign out_busy   = tx_full;

    io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push_c),
        .din   (out_data[7:0]),
        .pop   (tx_pop_c),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Ring arithmetic, arbitration inputs and the word being assembled.
    always_comb begin
        prod_next_c = (prod_pointer == ADDR_W'(RING_BASE + RING_DEPTH - 1))
                    ? ADDR_W'(RING_BASE) : prod_pointer + ADDR_W'(1);
        ring_full_c = (prod_next_c == consumer_pointer);
        last_lane_c = (byte_idx == 2'(BYTES_PER_WORD - 1));
        rx_ok_c     = stat[RX_VALID] && !(last_lane_c && ring_full_c);
        tx_ok_c     = tx_enabled && !tx_empty && !stat[TX_FULL];
        word_c      = pack;
        word_c[{byte_idx, 3'b000} +: 8] = axi_rdata[7:0];
        tx_push_c   = out_req && !tx_full;
        tx_pop_c    = (state == TX_B) && axi_bvalid && axi_bready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= STAT_AR;
            stat         <= '0;
            tx_enabled   <= 1'b0;
            last_tx      <= 1'b0;
            byte_idx     <= '0;
            pack         <= '0;
            prod_pointer <= ADDR_W'(RING_BASE);
            in_busy      <= !IGNORE_IN_BUSY;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            axi_awvalid  <= 1'b0;
            axi_awaddr   <= '0;
            axi_wvalid   <= 1'b0;
            axi_wdata    <= '0;
            axi_bready   <= 1'b0;
            axi_arvalid  <= 1'b0;
            axi_araddr   <= '0;
            axi_rready   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            // Pointer moves the cycle after the BRAM write so data lands first.
            if (mem_we) begin
                prod_pointer <= prod_next_c;
            end
            in_busy <= IGNORE_IN_BUSY ? 1'b0
                     : (consumer_pointer == (mem_we ? prod_next_c : prod_pointer));

            case (state)
                STAT_AR, RX_AR: begin
                    if (!axi_arvalid) begin
                        axi_arvalid <= 1'b1;
                        axi_araddr  <= UART_BASE + ((state == STAT_AR) ? STAT_OFS : RX_FIFO_OFS);
                    end else if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= (state == STAT_AR) ? STAT_R : RX_R;
                    end
                end
                STAT_R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        stat       <= axi_rdata[3:0];
                        if (axi_rdata[TX_EMPTY]) begin
                            tx_enabled <= 1'b1;
                        end
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (rx_ok_c && (!tx_ok_c || last_tx)) begin
                        state <= RX_AR;
                    end else if (tx_ok_c) begin
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                        axi_awaddr  <= UART_BASE + TX_FIFO_OFS;
                        axi_wdata   <= {24'b0, tx_dout};
                        state       <= TX_AW_W;
                    end else begin
                        state <= STAT_AR;
                    end
                end
                RX_R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        last_tx    <= 1'b0;
                        state      <= STAT_AR;
                        if (last_lane_c) begin
                            mem_we   <= 1'b1;
                            mem_addr <= prod_pointer;
                            mem_data <= word_c;
                            pack     <= '0;
                            byte_idx <= '0;
                        end else begin
                            pack     <= word_c;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                TX_AW_W: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                    end
                    if (axi_wready) begin
                        axi_wvalid <= 1'b0;
                    end
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        state      <= TX_B;
                    end
                end
                TX_B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        last_tx    <= 1'b1;
                        state      <= STAT_AR;
                    end
                end
                default: state <= STAT_AR;
            endcase
        end
    end

`ifdef UART_IO_ERR_CNT_EN
    logic resp_err_c;
    assign resp_err_c = (axi_rvalid && axi_rready && (axi_rresp != AXI_RESP_OKAY))
                     || (tx_pop_c && (axi_bresp != AXI_RESP_OKAY));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count <= '0;
        end else if (resp_err_c && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{axi_rdata[31:8], out_data[WORD_W-1:8]};
`else
    logic unused_bits;
    assign unused_bits = ^{axi_rdata[31:8], out_data[WORD_W-1:8], axi_rresp, axi_bresp};
`endif

endmodule

// File: tb/tb_axil_uart_io_ring.sv
// Directed bench for axil_uart_io_ring with a small AXI-lite UART slave model.
// Error-counter checks are compiled in when UART_IO_ERR_CNT_EN is defined.
module tb_axil_uart_io_ring;

    localparam logic [31:0] UART_BASE = 32'h0000_1000;
    localparam logic [7:0]  R_TAG     = 8'h52;
    localparam logic [7:0]  T_TAG     = 8'h54;

    logic        clk;
    logic        rstn;
    logic        out_req;
    logic [31:0] out_data;
    logic        out_busy;
    logic [7:0]  consumer_pointer;
    logic        in_busy;
    logic [7:0]  prod_pointer;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
`ifdef UART_IO_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    axil_uart_io_ring #(
        .BYTES_PER_WORD (4),
        .ADDR_W         (8),
        .RING_BASE      (8),
        .RING_DEPTH     (4),
        .TX_DEPTH       (16),
        .UART_BASE      (UART_BASE),
        .IGNORE_IN_BUSY (1'b0)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .out_req          (out_req),
        .out_data         (out_data),
        .out_busy         (out_busy),
        .consumer_pointer (consumer_pointer),
        .in_busy          (in_busy),
        .prod_pointer     (prod_pointer),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_we           (mem_we),
        .axi_awvalid      (axi_awvalid),
        .axi_awready      (axi_awready),
        .axi_awaddr       (axi_awaddr),
        .axi_awprot       (axi_awprot),
        .axi_wvalid       (axi_wvalid),
        .axi_wready       (axi_wready),
        .axi_wdata        (axi_wdata),
        .axi_wstrb        (axi_wstrb),
        .axi_bvalid       (axi_bvalid),
        .axi_bready       (axi_bready),
        .axi_bresp        (axi_bresp),
        .axi_arvalid      (axi_arvalid),
        .axi_arready      (axi_arready),
        .axi_araddr       (axi_araddr),
        .axi_arprot       (axi_arprot),
        .axi_rvalid       (axi_rvalid),
        .axi_rready       (axi_rready),
        .axi_rdata        (axi_rdata),
        .axi_rresp        (axi_rresp)
`ifdef UART_IO_ERR_CNT_EN
        ,
        .err_count        (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model state; everything is driven and sampled on the falling edge.
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  order_q[$];
    logic        ar_rdy_en, aw_rdy_en, w_rdy_en, stat_txfull;
    logic [1:0]  bresp_val;
    logic        aw_got, w_got;
    logic        p_arvalid, p_arready, p_rvalid, p_rready;
    logic        p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
    logic [31:0] p_araddr, p_wdata;
    int          memwe_cnt = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
            axi_rvalid  = 1'b0; axi_bvalid  = 1'b0;
            axi_rdata   = '0;   axi_rresp   = '0;   axi_bresp = '0;
            aw_got = 1'b0; w_got = 1'b0;
            p_arvalid = 1'b0; p_arready = 1'b0; p_rvalid = 1'b0; p_rready = 1'b0;
            p_awvalid = 1'b0; p_awready = 1'b0; p_wvalid = 1'b0; p_wready = 1'b0;
            p_bvalid  = 1'b0; p_bready  = 1'b0; p_araddr = '0; p_wdata = '0;
        end else begin
            if (p_rvalid && p_rready) axi_rvalid = 1'b0;
            if (p_bvalid && p_bready) axi_bvalid = 1'b0;
            if (p_arvalid && p_arready) begin
                axi_rvalid = 1'b1;
                axi_rresp  = 2'b00;
                if (p_araddr == UART_BASE + 32'h8) begin
                    axi_rdata = {28'b0, stat_txfull, 1'b1, 1'b0, (rx_q.size() != 0)};
                end else begin
                    order_q.push_back(R_TAG);
                    axi_rdata = '0;
                    if (rx_q.size() != 0) axi_rdata = {24'b0, rx_q.pop_front()};
                end
            end
            if (p_awvalid && p_awready) begin
                aw_got = 1'b1;
                order_q.push_back(T_TAG);
            end
            if (p_wvalid && p_wready) begin
                w_got = 1'b1;
                tx_log.push_back(p_wdata[7:0]);
            end
            if (aw_got && w_got) begin
                axi_bvalid = 1'b1;
                axi_bresp  = bresp_val;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
            if (mem_we) memwe_cnt++;
            axi_arready = ar_rdy_en;
            axi_awready = aw_rdy_en;
            axi_wready  = w_rdy_en;
            p_arvalid = axi_arvalid; p_arready = axi_arready; p_araddr = axi_araddr;
            p_rvalid  = axi_rvalid;  p_rready  = axi_rready;
            p_awvalid = axi_awvalid; p_awready = axi_awready;
            p_wvalid  = axi_wvalid;  p_wready  = axi_wready;  p_wdata = axi_wdata;
            p_bvalid  = axi_bvalid;  p_bready  = axi_bready;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        out_data = {24'b0, b};
        out_req  = 1'b1;
        @(negedge clk);
        out_req  = 1'b0;
    endtask

    task automatic wait_mem_we(input int limit);
        for (int k = 0; k < limit && !mem_we; k++) @(negedge clk);
        check("mem_we_seen", 32'(mem_we), 32'd1);
    endtask

    logic [7:0] exp_order [7];
    int         snap;

    initial begin
        rstn = 1'b0; out_req = 1'b0; out_data = '0; consumer_pointer = 8'd8;
        ar_rdy_en = 1'b1; aw_rdy_en = 1'b0; w_rdy_en = 1'b0;
        stat_txfull = 1'b0; bresp_val = 2'b00;
        exp_order = '{R_TAG, T_TAG, R_TAG, T_TAG, R_TAG, T_TAG, R_TAG};
        repeat (3) @(negedge clk);

        check("rst_arvalid", 32'(axi_arvalid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_prod", 32'(prod_pointer), 32'd8);
        check("rst_out_busy", 32'(out_busy), 32'd0);
        check("rst_araddr", axi_araddr, 32'd0);
        rstn = 1'b1;

        // Reset while a TX write is waiting on awready
        push_byte(8'h5A);
        for (int k = 0; k < 100 && !axi_awvalid; k++) @(negedge clk);
        check("t1_awvalid", 32'(axi_awvalid), 32'd1);
        check("t1_awaddr", axi_awaddr, 32'h0000_1004);
        check("t1_wdata", axi_wdata, 32'h0000_005A);
        check("t1_wstrb", 32'(axi_wstrb), 32'h1);
        check("t1_prot", 32'({axi_awprot, axi_arprot}), 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("t1_rst_awvalid", 32'(axi_awvalid), 32'd0);
        check("t1_rst_wvalid", 32'(axi_wvalid), 32'd0);
        check("t1_rst_arvalid", 32'(axi_arvalid), 32'd0);
        check("t1_rst_prod", 32'(prod_pointer), 32'd8);
        check("t1_rst_out_busy", 32'(out_busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // One packed RX word
        repeat (5) @(negedge clk);
        rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33); rx_q.push_back(8'h44);
        wait_mem_we(300);
        check("t2_data", mem_data, 32'h4433_2211);
        check("t2_addr", 32'(mem_addr), 32'd8);
        check("t2_prod_before", 32'(prod_pointer), 32'd8);
        check("t2_in_busy_before", 32'(in_busy), 32'd1);
        @(negedge clk);
        check("t2_prod_after", 32'(prod_pointer), 32'd9);
        check("t2_in_busy_after", 32'(in_busy), 32'd0);

        // Fill the 4-deep ring, then stall on the last byte of the next word
        for (int i = 1; i <= 8; i++) rx_q.push_back(8'(i));
        @(negedge clk);
        wait_mem_we(300);
        check("t3_w1_addr", 32'(mem_addr), 32'd9);
        check("t3_w1_data", mem_data, 32'h0403_0201);
        @(negedge clk);
        wait_mem_we(300);
        check("t3_w2_addr", 32'(mem_addr), 32'd10);
        check("t3_w2_data", mem_data, 32'h0807_0605);
        @(negedge clk);
        check("t3_prod_full", 32'(prod_pointer), 32'd11);
        rx_q.push_back(8'hA1); rx_q.push_back(8'hA2); rx_q.push_back(8'hA3); rx_q.push_back(8'hA4);
        snap = memwe_cnt;
        repeat (300) @(negedge clk);
        check("t3_stall_prod", 32'(prod_pointer), 32'd11);
        check("t3_stall_rxleft", 32'(rx_q.size()), 32'd1);
        check("t3_stall_nowrite", 32'(memwe_cnt - snap), 32'd0);
        consumer_pointer = 8'd9;
        wait_mem_we(300);
        check("t3_w4_addr", 32'(mem_addr), 32'd11);
        check("t3_w4_data", mem_data, 32'hA4A3_A2A1);
        @(negedge clk);
        check("t3_prod_wrap", 32'(prod_pointer), 32'd8);

        // Fill the TX FIFO with awready low, then drain in order
        for (int i = 0; i < 16; i++) begin
            out_data = 32'(i);
            out_req  = 1'b1;
            @(negedge clk);
            if (i == 14) check("t4_busy_15", 32'(out_busy), 32'd0);
        end
        check("t4_busy_16", 32'(out_busy), 32'd1);
        out_data = 32'h0000_00EE;
        @(negedge clk);
        out_req = 1'b0;
        aw_rdy_en = 1'b1; w_rdy_en = 1'b1;
        for (int k = 0; k < 2000 && tx_log.size() < 16; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        check("t4_count", 32'(tx_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("t4_byte", (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(i));
        end
        check("t4_busy_drained", 32'(out_busy), 32'd0);

        // RX and TX alternate when both have work
        ar_rdy_en = 1'b0;
        repeat (20) @(negedge clk);
        consumer_pointer = 8'd8;
        rx_q.push_back(8'hB1); rx_q.push_back(8'hB2); rx_q.push_back(8'hB3); rx_q.push_back(8'hB4);
        push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
        order_q.delete();
        tx_log.delete();
        ar_rdy_en = 1'b1;
        for (int k = 0; k < 2000 && (tx_log.size() < 3 || rx_q.size() != 0); k++) @(negedge clk);
        repeat (50) @(negedge clk);
        check("t5_order_len", 32'(order_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check("t5_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end
        check("t5_prod", 32'(prod_pointer), 32'd9);

        // UART TX full blocks writes
        stat_txfull = 1'b1;
        tx_log.delete();
        push_byte(8'hD7);
        repeat (100) @(negedge clk);
        check("t5_txfull_blocked", 32'(tx_log.size()), 32'd0);
        stat_txfull = 1'b0;
        for (int k = 0; k < 200 && tx_log.size() < 1; k++) @(negedge clk);
        check("t5_txfull_released", (tx_log.size() != 0) ? 32'(tx_log[0]) : 32'hFFFF_FFFF, 32'hD7);

`ifdef UART_IO_ERR_CNT_EN
        // Error responses are counted and the bytes are not retried
        repeat (20) @(negedge clk);
        tx_log.delete();
        bresp_val = 2'b10;
        push_byte(8'hE1);
        push_byte(8'hE2);
        for (int k = 0; k < 500 && tx_log.size() < 2; k++) @(negedge clk);
        repeat (100) @(negedge clk);
        bresp_val = 2'b00;
        check("t6_err_count", 32'(err_count), 32'd2);
        check("t6_no_retry", 32'(tx_log.size()), 32'd2);
        check("t6_out_busy", 32'(out_busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
